// File: rtl/cache_pkg.sv
// Shared cache definitions: line geometry and refill FSM states.
// Used by the refill controller, its interface and the data cache.
package cache_pkg;

    localparam int WORDS_PER_LINE = 4;
    localparam int OFF_W          = 2;
    localparam int LINE_W         = 128;

    // Nominal memory read latency; the controller itself only follows rvalid.
    localparam int MEM_LAT        = 2;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FILL
    } refill_state_t;

endpackage

// File: rtl/cache_refill_ctrl_if.sv
// Refill bundle: cache miss request, memory read port, critical word and line fill.
// master = refill controller, slave = cache plus data memory.
interface cache_refill_ctrl_if
    import cache_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int WORD_W = 32
);

    logic                             miss_req;
    logic [ADDR_W-1:0]                miss_addr;
    logic                             busy;

    logic                             mem_rd_en;
    logic [ADDR_W-1:0]                mem_addr;
    logic [WORD_W-1:0]                mem_rdata;
    logic                             mem_rvalid;

    logic                             word_valid;
    logic [WORD_W-1:0]                word_out;

    logic                             fill_valid;
    logic [ADDR_W-OFF_W-1:0]          fill_addr;
    logic [WORDS_PER_LINE*WORD_W-1:0] fill_data;

    modport master (
        input  miss_req, miss_addr, mem_rdata, mem_rvalid,
        output busy, mem_rd_en, mem_addr,
        output word_valid, word_out,
        output fill_valid, fill_addr, fill_data
    );

    modport slave (
        output miss_req, miss_addr, mem_rdata, mem_rvalid,
        input  busy, mem_rd_en, mem_addr,
        input  word_valid, word_out,
        input  fill_valid, fill_addr, fill_data
    );

endinterface

// File: rtl/cache_refill_ctrl.sv
// Miss-refill controller: critical-word-first 4-word line fetch with wrap.
// Ports: clk, rst (async, active-low), bus (cache_refill_ctrl_if.master).
module cache_refill_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int WORD_W = 32
) (
    input logic                 clk,
    input logic                 rst,
    cache_refill_ctrl_if.master bus
);

    localparam int LN_W = ADDR_W - OFF_W;

    refill_state_t     r_state;
    refill_state_t     w_next;

    logic [LN_W-1:0]   r_line;
    logic [OFF_W-1:0]  r_off;
    logic [OFF_W-1:0]  r_issue_cnt;
    logic [OFF_W-1:0]  r_ret_cnt;
    logic [WORD_W-1:0] r_buf [WORDS_PER_LINE];
    logic [WORD_W-1:0] r_word_out;
    logic              r_word_valid;

    logic [OFF_W-1:0]  w_iss_slot;
    logic [OFF_W-1:0]  w_ret_slot;
    logic              w_accept;
    logic              w_cap;
    logic              w_last_ret;

    assign w_accept   = (r_state == IDLE) && bus.miss_req;
    assign w_cap      = bus.mem_rvalid &&
                        ((r_state == ISSUE) || (r_state == DRAIN));
    assign w_last_ret = w_cap && (&r_ret_cnt);

    // Offset arithmetic is 2-bit, so the wrap inside the line is free.
    assign w_iss_slot = r_off + r_issue_cnt;
    assign w_ret_slot = r_off + r_ret_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) w_next = ISSUE;
            end
            ISSUE: begin
                // A zero-latency memory can finish on the last issue cycle.
                if (w_last_ret)          w_next = FILL;
                else if (&r_issue_cnt)   w_next = DRAIN;
            end
            DRAIN: begin
                if (w_last_ret) w_next = FILL;
            end
            FILL: begin
                w_next = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.busy       = (r_state != IDLE);
        bus.mem_rd_en  = (r_state == ISSUE);
        bus.mem_addr   = '0;
        bus.fill_valid = (r_state == FILL);
        if (r_state == ISSUE) bus.mem_addr = {r_line, w_iss_slot};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_line       <= '0;
            r_off        <= '0;
            r_issue_cnt  <= '0;
            r_ret_cnt    <= '0;
            r_word_out   <= '0;
            r_word_valid <= 1'b0;
            for (int i = 0; i < WORDS_PER_LINE; i++) r_buf[i] <= '0;
        end else begin
            r_word_valid <= 1'b0;
            if (w_accept) begin
                r_line      <= bus.miss_addr[ADDR_W-1:OFF_W];
                r_off       <= bus.miss_addr[OFF_W-1:0];
                r_issue_cnt <= '0;
                r_ret_cnt   <= '0;
            end
            if (r_state == ISSUE) r_issue_cnt <= r_issue_cnt + 1'b1;
            if (w_cap) begin
                r_buf[w_ret_slot] <= bus.mem_rdata;
                r_ret_cnt         <= r_ret_cnt + 1'b1;
                // First return is always the missed word.
                if (r_ret_cnt == '0) begin
                    r_word_out   <= bus.mem_rdata;
                    r_word_valid <= 1'b1;
                end
            end
        end
    end

    assign bus.word_valid = r_word_valid;
    assign bus.word_out   = r_word_out;
    assign bus.fill_addr  = r_line;

    always_comb begin
        bus.fill_data = '0;
        for (int j = 0; j < WORDS_PER_LINE; j++) begin
            bus.fill_data[j*WORD_W +: WORD_W] = r_buf[j];
        end
    end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl with a latency-L memory model
// and a scoreboard of expected issues, critical words and line fills.
module tb_cache_refill_ctrl;
    import cache_pkg::*;

    localparam int L = MEM_LAT;

    typedef struct { logic [14:0] addr; int cyc; } ma_t;
    typedef struct { logic [31:0] data; int cyc; } wv_t;
    typedef struct {
        logic [12:0]  addr;
        logic [127:0] data;
        int           cyc;
    } fv_t;
    typedef struct { logic [14:0] addr; int due; } rd_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    ma_t  exp_ma[$];
    wv_t  exp_wv[$];
    fv_t  exp_fv[$];
    rd_t  pend[$];

    int   m_bs = 0;
    int   m_be = -1;
    int   acc_cnt = 0;
    int   fill_cnt = 0;
    int   gap_cfg = 0;
    int   gap_left = 0;
    int   ret_n = 0;
    bit   mb;
    ma_t  ma;
    wv_t  wv;
    fv_t  fv;
    logic [12:0]  m_line;
    logic [1:0]   m_off;
    logic [127:0] m_fd;

    cache_refill_ctrl_if #(.ADDR_W(15), .WORD_W(32)) bus ();

    cache_refill_ctrl #(.ADDR_W(15), .WORD_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mdata(input logic [14:0] a);
        return 32'hA000 + {17'd0, a};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"},       bus.busy,       0);
        chk({tag, "_mem_rd_en"},  bus.mem_rd_en,  0);
        chk({tag, "_mem_addr"},   bus.mem_addr,   0);
        chk({tag, "_word_valid"}, bus.word_valid, 0);
        chk({tag, "_word_out"},   bus.word_out,   0);
        chk({tag, "_fill_valid"}, bus.fill_valid, 0);
        chk({tag, "_fill_addr"},  bus.fill_addr,  0);
        chk({tag, "_fill_data"},  bus.fill_data,  0);
    endtask

    // Memory: each read returns L cycles after issue, in order.
    always @(negedge clk) begin
        if (bus.mem_rd_en === 1'b1) pend.push_back('{bus.mem_addr, cyc + L});
    end

    always @(posedge clk) begin
        #1;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            if (ret_n == 2 && gap_left > 0) begin
                gap_left--;
            end else begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = mdata(pend[0].addr);
                void'(pend.pop_front());
                ret_n++;
            end
        end
    end

    // Scoreboard and acceptance model.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            exp_ma.delete();
            exp_wv.delete();
            exp_fv.delete();
            m_be     = -1;
            gap_left = 0;
        end else begin
            mb = (cyc >= m_bs) && (cyc <= m_be);
            chk("busy", bus.busy, mb);
            chk("pulse_overlap", bus.word_valid & bus.fill_valid, 0);
            if (bus.mem_rd_en === 1'b1) begin
                chk("issue_expected", exp_ma.size() > 0, 1);
                if (exp_ma.size() > 0) begin
                    ma = exp_ma.pop_front();
                    chk("mem_addr", bus.mem_addr, ma.addr);
                    chk("issue_cycle", cyc, ma.cyc);
                end
            end
            if (bus.word_valid === 1'b1) begin
                chk("word_expected", exp_wv.size() > 0, 1);
                if (exp_wv.size() > 0) begin
                    wv = exp_wv.pop_front();
                    chk("word_out", bus.word_out, wv.data);
                    chk("word_cycle", cyc, wv.cyc);
                end
            end
            if (bus.fill_valid === 1'b1) begin
                fill_cnt++;
                chk("fill_expected", exp_fv.size() > 0, 1);
                if (exp_fv.size() > 0) begin
                    fv = exp_fv.pop_front();
                    chk("fill_addr", bus.fill_addr, fv.addr);
                    chk("fill_data", bus.fill_data, fv.data);
                    chk("fill_cycle", cyc, fv.cyc);
                end
            end
            if (bus.miss_req === 1'b1 && !mb) begin
                m_line = bus.miss_addr[14:2];
                m_off  = bus.miss_addr[1:0];
                for (int i = 0; i < 4; i++) begin
                    exp_ma.push_back('{{m_line, 2'(m_off + i)}, cyc + 1 + i});
                end
                exp_wv.push_back('{mdata(bus.miss_addr), cyc + 2 + L});
                for (int j = 0; j < 4; j++) begin
                    m_fd[32*j +: 32] = mdata({m_line, 2'(j)});
                end
                exp_fv.push_back('{m_line, m_fd, cyc + 5 + L + gap_cfg});
                m_bs     = cyc + 1;
                m_be     = cyc + 5 + L + gap_cfg;
                gap_left = gap_cfg;
                ret_n    = 0;
                acc_cnt++;
            end
        end
    end

    task automatic wait_acc(input int target);
        int n = 0;
        while (n < 30 && acc_cnt < target) begin
            @(posedge clk); #2;
            n++;
        end
        chk("accept_in_time", acc_cnt >= target, 1);
    endtask

    task automatic refill(input logic [14:0] a, input int gap);
        int n0 = acc_cnt;
        @(posedge clk); #2;
        gap_cfg       = gap;
        bus.miss_addr = a;
        bus.miss_req  = 1'b1;
        wait_acc(n0 + 1);
        bus.miss_req  = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (n < 60 && !(exp_ma.size() == 0 && exp_wv.size() == 0 &&
                           exp_fv.size() == 0 && cyc > m_be)) begin
            @(posedge clk); #2;
            n++;
        end
        chk("drain_in_time", n < 60, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "bench did not finish");
    end

    initial begin
        int n0;
        int f0;
        int n;

        rst           = 1'b0;
        bus.miss_req  = 1'b1;
        bus.miss_addr = 15'h0100;
        repeat (3) begin
            @(negedge clk);
            check_zero("reset");
        end
        @(posedge clk); #2;
        bus.miss_req = 1'b0;
        rst          = 1'b1;

        refill(15'h0100, 0);
        wait_idle();
        chk("aligned_word_hold", bus.word_out, 32'hA100);
        chk("aligned_fill_addr", bus.fill_addr, 13'h040);
        chk("aligned_fill_data", bus.fill_data,
            {32'hA103, 32'hA102, 32'hA101, 32'hA100});

        refill(15'h7FFF, 0);
        wait_idle();
        chk("wrap_word_hold", bus.word_out, 32'h0001_1FFF);
        chk("wrap_fill_addr", bus.fill_addr, 13'h1FFF);
        chk("wrap_fill_data", bus.fill_data,
            {32'h0001_1FFF, 32'h0001_1FFE, 32'h0001_1FFD, 32'h0001_1FFC});

        refill(15'h0208, 3);
        wait_idle();
        chk("gap_fill_data", bus.fill_data,
            {32'hA20B, 32'hA20A, 32'hA209, 32'hA208});

        n0 = acc_cnt;
        f0 = fill_cnt;
        @(posedge clk); #2;
        gap_cfg       = 0;
        bus.miss_addr = 15'h0300;
        bus.miss_req  = 1'b1;
        wait_acc(n0 + 1);
        bus.miss_addr = 15'h0406;
        wait_acc(n0 + 2);
        bus.miss_req  = 1'b0;
        wait_idle();
        chk("b2b_fill_count", fill_cnt - f0, 2);
        chk("b2b_last_word", bus.word_out, 32'hA406);

        refill(15'h0512, 0);
        n = 0;
        while (n < 30 && ret_n < 2) begin
            @(posedge clk); #2;
            n++;
        end
        chk("two_returns_seen", ret_n >= 2, 1);
        f0 = fill_cnt;
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check_zero("abort");
        @(posedge clk); #2;
        rst = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        chk("abort_no_fill", fill_cnt - f0, 0);
        chk("abort_idle", bus.busy, 0);
        chk("stray_drained", pend.size(), 0);

        refill(15'h0516, 0);
        wait_idle();
        chk("after_abort_fill", bus.fill_data,
            {32'hA517, 32'hA516, 32'hA515, 32'hA514});

        chk("scoreboard_empty",
            exp_ma.size() + exp_wv.size() + exp_fv.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_refill_ctrl.md
# cache_refill_ctrl

Miss-refill controller between the direct-mapped data cache and the 32-bit data memory. On a cache miss it fetches the 4-word (128-bit) line containing the missed address with four pipelined word reads. Reads are issued critical-word-first with wrap-around. The missed word is forwarded as soon as it arrives, and the assembled line is delivered to the cache for allocation.

## Interface
- `ADDR_W`, 15: word address width.
- `WORD_W`, 32: data word width.
- `MEM_LAT`, 2: informational only, the nominal memory read latency; the design relies only on `mem_rvalid`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `miss_req` in 1: cache miss request.
- `miss_addr` in ADDR_W: missed word address; bits [1:0] are the word offset, bits [14:2] the line address.
- `busy` out 1: refill in progress; requests are not accepted while high.
- `mem_rd_en` out 1: memory read strobe, one word per cycle.
- `mem_addr` out ADDR_W: memory read word address.
- `mem_rdata` in WORD_W: memory read data.
- `mem_rvalid` in 1: `mem_rdata` valid; returns arrive in issue order.
- `word_valid` out 1: one-cycle pulse, critical word ready.
- `word_out` out WORD_W: critical (missed) word.
- `fill_valid` out 1: one-cycle pulse, line ready for cache write.
- `fill_addr` out ADDR_W-2: line address of the fill.
- `fill_data` out 4*WORD_W: line data; word j is at [32j+31:32j].

## Operation
- **FSM states:** IDLE, ISSUE, DRAIN, FILL.
- **IDLE**
  - A request is accepted at a clock edge where `miss_req`=1 and `busy`=0.
  - On acceptance: latch line address and offset `off`, clear `issue_cnt` and `ret_cnt`, go to ISSUE.
- **ISSUE**
  - `mem_rd_en`=1 every cycle.
  - `mem_addr` = {line, (off+issue_cnt) mod 4}.
  - `issue_cnt` increments each cycle (2-bit, wraps).
  - After the 4th issue, go to DRAIN.
- **Return capture (ISSUE and DRAIN)**
  - Each `mem_rvalid` writes `mem_rdata` into slot (off+ret_cnt) mod 4, then `ret_cnt` increments.
  - The return with `ret_cnt`=0 is the critical word: register it into `word_out` and pulse `word_valid` the next cycle.
  - The 4th return moves the FSM to FILL. If the 4th return arrives on the last ISSUE cycle, go directly to FILL.
- **FILL**
  - `fill_valid`=1 for one cycle with `fill_addr`/`fill_data`, then go to IDLE.
- `busy`=1 in ISSUE, DRAIN and FILL.
- `mem_rvalid` in IDLE is ignored, and no state changes.
- `miss_req` while `busy`=1 is ignored. The requester holds `miss_req` until it sees `busy`.
- `word_out`, `fill_data` and `fill_addr` hold their last values until overwritten by the next refill.

## Timing
- **Reset:** while `rst`=0, and immediately on assertion:
  - FSM goes to IDLE.
  - All outputs are 0: `busy`, `mem_rd_en`, `mem_addr`, `word_valid`, `word_out`, `fill_valid`, `fill_addr`, `fill_data`.
  - Counters and the line buffer are 0.
  - A reset mid-refill aborts it, and no pulses are produced.
- **Cycle timing:** request accepted at edge 0, memory returns at issue+L.
  - `mem_rd_en` is high in cycles 1–4.
  - `mem_rvalid` is high in cycles 1+L … 4+L.
  - `word_valid` is high in cycle 2+L.
  - `fill_valid` is high in cycle 5+L.
  - `busy` is high from cycle 1 through 5+L.
  - A new request can be accepted at the first edge after `busy` falls.
- **With L=2:** `word_valid` at 4, `fill_valid` at 7. Minimum refill-to-refill spacing is 6+L cycles.
- **Gapped returns:** the design tolerates gaps in `mem_rvalid`; DRAIN waits indefinitely.
- `word_valid` and `fill_valid` never coincide.
- **Wrap order, off=3:** issue order is 3, 0, 1, 2, and `fill_data` is still placed by word index.

## Structure
- Package `cache_pkg`: `WORDS_PER_LINE`=4, `OFF_W`=2, `LINE_W`=128, state enum `refill_state_t`. The package is shared with the cache.
- A single module is the natural structure. The 4×32 line buffer is an inline register array; no sub-module is needed.

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles with `miss_req`=1 → all outputs 0, `busy` stays 0.
- **Aligned miss:** `miss_addr`=15'h0100, memory model L=2 returns data=addr+32'hA000 → expected response:
  - `mem_addr` sequence 100, 101, 102, 103.
  - `word_out`=A100 at cycle 4.
  - `fill_valid` at cycle 7, `fill_addr`=13'h040, `fill_data`={A103, A102, A101, A100}.
- **Wrap-around:** `miss_addr`=15'h7FFF → expected response:
  - Issue sequence 7FFF, 7FFC, 7FFD, 7FFE.
  - `word_out`=data(7FFF).
  - `fill_data` slots ordered by index.
- **Gapped returns:** drop `mem_rvalid` for 3 cycles between the 2nd and 3rd returns → `fill_valid` is delayed by exactly 3 cycles, data is correct, and `busy` stays high throughout.
- **Back-to-back and busy:** `miss_req` held high across two different lines → the second request is accepted only after `busy` falls, and the one-cycle `fill_valid` pulse per line is never merged.
- **Reset mid-refill:** assert `rst`=0 after the 2nd return, release, feed the remaining stray `mem_rvalid` → no `fill_valid`, the FSM stays IDLE, and the next refill completes correctly.
